fir_filter_param: RTL and testbench
===================================

// Module: fir_filter_param
// PURPOSE
//  Parametrised FIR filter core: NTAPS signed taps, runtime-loadable coefficients.
//  Uses a sequential single-multiplier MAC; a FSM sequences shift/MAC/writeback.
//  Output is the magnitude of the scaled result. Sits between the sample source
//  (AHB/APB slave or test driver) and the consumer. Next-gen 4-tap fixed filter.
// PARAMETERS
//  DATA_W      16    sample width (signed two's complement); also fir_out width
//  COEF_W      16    coefficient width (signed, Q1.FRAC_W)
//  NTAPS       4     number of taps (>=2)
//  FRAC_W      15    right-shift applied to accumulator before magnitude
//  SAMPLE_CNT  1000  completed-sample count that pulses one_k_samples
// PORTS
//  clk              in   1       system clock, rising edge
//  n_reset          in   1       asynchronous active-low reset
//  sample_data      in   DATA_W  new sample, captured on data_ready rising edge
//  data_ready       in   1       level; rising edge requests one sample
//  fir_coefficient  in   COEF_W  coefficient, captured on load_coeff rising edge
//  load_coeff       in   1       level; rising edge loads next coefficient
//  modwait          out  1       core busy (LOAD/SHIFT/MAC/DONE)
//  coeff_ready      out  1       all NTAPS coefficients loaded since reset
//  out_valid        out  1       1-cycle pulse, fir_out updated
//  fir_out          out  DATA_W  |acc >>> FRAC_W|, unsigned
//  one_k_samples    out  1       1-cycle pulse every SAMPLE_CNT results
//  err              out  1       sticky error, cleared on next accepted sample
// BEHAVIOUR
//  Reset: all outputs 0; coefficients, delay line, accumulator, counters, ptr = 0; FSM IDLE.
//  Inputs synchronous; edge detect via registered copy (reset 0). Held level = one request.
//  FSM: IDLE -> LOAD (1 cyc) -> IDLE; IDLE -> SHIFT (1) -> MAC (NTAPS) -> DONE (1) -> IDLE.
//  IDLE: load_coeff edge wins over simultaneous data_ready edge; data edge then dropped, err=1.
//  LOAD: coef[ptr] <= fir_coefficient; ptr wraps NTAPS-1 -> 0; coeff_ready sets at first wrap,
//   stays 1; first load after coeff_ready clears sample counter.
//  SHIFT: x[k] <= x[k-1], x[0] <= sample_data (captured at accept); acc <= 0; err <= 0.
//  MAC cycle k (0..NTAPS-1): acc += x[k]*coef[k]; ACC_W = DATA_W+COEF_W+clog2(NTAPS).
//  DONE: r = acc >>> FRAC_W; m = |r|; overflow if m > 2^DATA_W-1 -> err=1.
//   fir_out/out_valid update on edge ending DONE; latency accept edge -> out_valid = NTAPS+3.
//  modwait high NTAPS+2 cycles per sample (default 6), 1 cycle per coefficient load.
//  data_ready edge while modwait=1 or coeff_ready=0: sample dropped, err=1, no state change.
//  Counter increments in DONE; at SAMPLE_CNT-1 -> one_k_samples pulses with out_valid, wraps 0.
//  Reset mid-operation: immediate return to reset state; no partial output.
// CONFIGURATION
//  FIR_SATURATE_EN defined: overflow clamps fir_out to 2^DATA_W-1 (err still set).
//  Not defined: fir_out = m[DATA_W-1:0] (wrap), err set.
// STRUCTURE
//  fir_pkg: state_t enum {IDLE,LOAD,SHIFT,MAC,DONE}, ACC_W/clog2 helper functions.
//  Sub-module fir_mac: signed multiply-accumulate with clear/enable, ACC_W output.
//  Top holds FSM, coefficient RAM/regs, delay line, counter, magnitude/clamp.
// TESTING (NTAPS=4, FRAC_W=15)
//  Load 4x 0x4000; sample 100 -> after 7 cycles out_valid, fir_out=50, err=0.
//  Next sample 100 -> fir_out=100; then -200 (0xFF38) -> 0 (100+... = 50+50-100).
//  Coefs 0x7FFF x4, samples 0x7FFF x4 -> 4th result err=1; SAT: 0xFFFF; else 0xFFF8.
//  data_ready edge during MAC -> err=1, dropped, next result unaffected; next accept clears err.
//  data_ready before coeff_ready -> err=1, no out_valid; load+data same cycle -> load wins.
//  SAMPLE_CNT=5 override: one_k_samples pulses on results 5,10; n_reset mid-MAC -> all 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parametrised FIR core.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        MAC,
        DONE
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width: full product plus growth for summing ntaps products.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned ntaps);
        return data_w + coef_w + clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
    parameter int unsigned A_W   = 16,
    parameter int unsigned B_W   = 16,
    parameter int unsigned ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Sequential single-MAC FIR filter with runtime-loadable coefficients.
// Define FIR_SATURATE_EN to clamp overflowing magnitudes instead of wrapping.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned COEF_W     = 16,
    parameter int unsigned NTAPS      = 4,
    parameter int unsigned FRAC_W     = 15,
    parameter int unsigned SAMPLE_CNT = 1000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              data_ready,
    input  logic [COEF_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    output logic              modwait,
    output logic              coeff_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] fir_out,
    output logic              one_k_samples,
    output logic              err
);

    localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
    localparam int unsigned IDX_W = clog2(NTAPS);
    localparam int unsigned CNT_W = (clog2(SAMPLE_CNT) > 0) ? clog2(SAMPLE_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_CNT - 1);

    state_t                   state;
    logic [IDX_W-1:0]         ptr;
    logic [IDX_W-1:0]         k;
    logic [CNT_W-1:0]         cnt;
    logic                     data_d1, data_d2;
    logic                     load_d1, load_d2;
    logic                     data_rise, load_rise;
    logic signed [DATA_W-1:0] x    [NTAPS];
    logic signed [COEF_W-1:0] coef [NTAPS];
    logic signed [DATA_W-1:0] sample_q;
    logic signed [COEF_W-1:0] coef_q;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic [ACC_W-1:0]         mag;
    logic                     overflow;
    logic [DATA_W-1:0]        result;

    // Registered copies of the level inputs; a held level yields one request.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_d1 <= 1'b0;
            data_d2 <= 1'b0;
            load_d1 <= 1'b0;
            load_d2 <= 1'b0;
        end else begin
            data_d1 <= data_ready;
            data_d2 <= data_d1;
            load_d1 <= load_coeff;
            load_d2 <= load_d1;
        end
    end

    assign data_rise = data_d1 & ~data_d2;
    assign load_rise = load_d1 & ~load_d2;

    assign mac_clr = (state == SHIFT);
    assign mac_en  = (state == MAC);

    fir_mac #(
        .A_W  (DATA_W),
        .B_W  (COEF_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk    (clk),
        .n_reset(n_reset),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (x[k]),
        .b      (coef[k]),
        .acc    (acc)
    );

    // Scale, take magnitude and resolve overflow of the final accumulator.
    always_comb begin
        scaled   = acc >>> FRAC_W;
        mag      = scaled[ACC_W-1] ? ACC_W'(-scaled) : ACC_W'(scaled);
        overflow = |mag[ACC_W-1:DATA_W];
`ifdef FIR_SATURATE_EN
        result   = overflow ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
`else
        result   = mag[DATA_W-1:0];
`endif
    end

    // Sequencer: coefficient load, delay-line shift, MAC sweep, writeback.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state         <= IDLE;
            ptr           <= '0;
            k             <= '0;
            cnt           <= '0;
            sample_q      <= '0;
            coef_q        <= '0;
            modwait       <= 1'b0;
            coeff_ready   <= 1'b0;
            out_valid     <= 1'b0;
            fir_out       <= '0;
            one_k_samples <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= '0;
            end
        end else begin
            out_valid     <= 1'b0;
            one_k_samples <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_rise) begin
                        coef_q  <= fir_coefficient;
                        state   <= LOAD;
                        modwait <= 1'b1;
                        if (data_rise) begin
                            err <= 1'b1;
                        end
                    end else if (data_rise) begin
                        if (coeff_ready) begin
                            sample_q <= sample_data;
                            state    <= SHIFT;
                            modwait  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    coef[ptr] <= coef_q;
                    if (ptr == LAST_IDX) begin
                        ptr         <= '0;
                        coeff_ready <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                    // Start of a fresh coefficient set restarts the result count.
                    if (coeff_ready && ptr == '0) begin
                        cnt <= '0;
                    end
                    if (data_rise) begin
                        err <= 1'b1;
                    end
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
                SHIFT: begin
                    for (int i = 1; i < NTAPS; i++) begin
                        x[i] <= x[i-1];
                    end
                    x[0]  <= sample_q;
                    err   <= data_rise;
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    if (data_rise) begin
                        err <= 1'b1;
                    end
                    if (k == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    fir_out   <= result;
                    out_valid <= 1'b1;
                    if (overflow || data_rise) begin
                        err <= 1'b1;
                    end
                    if (cnt == LAST_CNT) begin
                        cnt           <= '0;
                        one_k_samples <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed, scoreboarded bench for fir_filter_param (NTAPS=4, FRAC_W=15, SAMPLE_CNT=5).
module tb_fir_filter_param;

    localparam int unsigned SCNT = 5;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] sample_data = '0;
    logic        data_ready = 1'b0;
    logic [15:0] fir_coefficient = '0;
    logic        load_coeff = 1'b0;
    logic        modwait, coeff_ready, out_valid, one_k_samples, err;
    logic [15:0] fir_out;

    typedef struct {
        logic [15:0] fo;
        logic        e;
        logic        ok;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_coef[4];
    int   m_x[4];
    int   mptr = 0;
    bit   m_cr = 0;
    int   mcnt = 0;

    fir_filter_param #(
        .DATA_W(16), .COEF_W(16), .NTAPS(4), .FRAC_W(15), .SAMPLE_CNT(SCNT)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .sample_data    (sample_data),
        .data_ready     (data_ready),
        .fir_coefficient(fir_coefficient),
        .load_coeff     (load_coeff),
        .modwait        (modwait),
        .coeff_ready    (coeff_ready),
        .out_valid      (out_valid),
        .fir_out        (fir_out),
        .one_k_samples  (one_k_samples),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mptr = 0;
        m_cr = 0;
        mcnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_coef[i] = 0;
            m_x[i] = 0;
        end
    endtask

    task automatic model_load(input logic [15:0] c);
        if (m_cr && mptr == 0) mcnt = 0;
        m_coef[mptr] = int'($signed(c));
        if (mptr == 3) begin
            mptr = 0;
            m_cr = 1;
        end else begin
            mptr++;
        end
    endtask

    task automatic model_sample(input logic [15:0] s, input bit drop_mid, input int start_cyc);
        longint acc, r, m;
        bit     ovf;
        exp_t   e;
        for (int i = 3; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = int'($signed(s));
        acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(m_x[i]) * longint'(m_coef[i]);
        r = acc >>> 15;
        m = (r < 0) ? -r : r;
        ovf = (m > 65535);
`ifdef FIR_SATURATE_EN
        e.fo = ovf ? 16'hFFFF : m[15:0];
`else
        e.fo = m[15:0];
`endif
        e.e   = ovf | drop_mid;
        e.ok  = (mcnt == SCNT - 1);
        mcnt  = e.ok ? 0 : mcnt + 1;
        e.cyc = start_cyc + 8;
        q.push_back(e);
    endtask

    // Scoreboard: every out_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (n_reset && one_k_samples && !out_valid) check("one_k_without_valid", 1, 0);
        if (n_reset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("fir_out", 32'(fir_out), 32'(e.fo));
                check("err_at_out", 32'(err), 32'(e.e));
                check("one_k_samples", 32'(one_k_samples), 32'(e.ok));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic load_coef(input logic [15:0] c, input bit with_data);
        int mw = 0;
        @(negedge clk);
        fir_coefficient = c;
        load_coeff = 1'b1;
        data_ready = with_data;
        model_load(c);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            load_coeff = 1'b0;
            data_ready = 1'b0;
            if (modwait) mw++;
        end
        check("load_modwait_len", 32'(mw), 32'd1);
        if (with_data) check("load_wins_err", 32'(err), 32'd1);
    endtask

    task automatic send_sample(input logic [15:0] s, input bit accept, input bit inject);
        int mw = 0;
        @(negedge clk);
        sample_data = s;
        data_ready = 1'b1;
        if (accept) model_sample(s, inject, cyc);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0 || j == 4) data_ready = 1'b0;
            if (j == 3 && inject) data_ready = 1'b1;
            if (modwait) mw++;
        end
        check("sample_modwait_len", 32'(mw), accept ? 32'd6 : 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_modwait"}, 32'(modwait), 0);
        check({tag, "_coeff_ready"}, 32'(coeff_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_fir_out"}, 32'(fir_out), 0);
        check({tag, "_one_k"}, 32'(one_k_samples), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Sample before any coefficient: dropped with error, no result.
        send_sample(16'd100, 1'b0, 1'b0);
        check("drop_no_coef_err", 32'(err), 1);
        check("drop_no_coef_ready", 32'(coeff_ready), 0);

        @(negedge clk);
        n_reset = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset2");
        @(negedge clk);
        n_reset = 1'b1;

        // Load with simultaneous data edge: load wins, data dropped.
        load_coef(16'h4000, 1'b1);
        load_coef(16'h4000, 1'b0);
        load_coef(16'h4000, 1'b0);
        check("coeff_ready_after_3", 32'(coeff_ready), 0);
        load_coef(16'h4000, 1'b0);
        check("coeff_ready_after_4", 32'(coeff_ready), 1);

        send_sample(16'd100, 1'b1, 1'b0);
        check("first_result_50", 32'(fir_out), 32'd50);
        check("first_result_err", 32'(err), 0);
        send_sample(16'd100, 1'b1, 1'b0);
        check("second_result_100", 32'(fir_out), 32'd100);
        send_sample(16'hFF38, 1'b1, 1'b0);
        check("third_result_0", 32'(fir_out), 32'd0);

        // Request during MAC is dropped and flags err; next accept clears it.
        send_sample(16'd7, 1'b1, 1'b1);
        check("drop_mid_err", 32'(err), 1);
        send_sample(16'd8, 1'b1, 1'b0);
        check("err_cleared", 32'(err), 0);

        // Full-scale coefficients and samples: fourth result overflows.
        for (int i = 0; i < 4; i++) load_coef(16'h7FFF, 1'b0);
        for (int i = 0; i < 4; i++) send_sample(16'h7FFF, 1'b1, 1'b0);
`ifdef FIR_SATURATE_EN
        check("overflow_value", 32'(fir_out), 32'hFFFF);
`else
        check("overflow_value", 32'(fir_out), 32'hFFF8);
`endif
        check("overflow_err", 32'(err), 1);
        for (int i = 0; i < 6; i++) send_sample(16'(i * 3), 1'b1, 1'b0);

        // Reset in the middle of a MAC sweep.
        @(negedge clk);
        sample_data = 16'd5;
        data_ready = 1'b1;
        repeat (4) @(negedge clk);
        data_ready = 1'b0;
        n_reset = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_mid_mac");
        @(negedge clk);
        n_reset = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_no_coef", 32'(coeff_ready), 0);
        check("scoreboard_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
